// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the keyboard decoder and the move command
// sequencer.
//   state_t    game-mode FSM states
//   dir_t      2-bit move direction, with the DIR_* constants
//   KEY_*      keyboard scan codes used by the decoder
//   btn_to_dir picks one direction from simultaneous button pulses
package game_pkg;

  typedef enum logic [2:0] {
    S_MENU,
    S_CLEAR,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OVER
  } state_t;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_R     = 8'h15;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_M     = 8'h10;

  // btn[0]=btn1 (left), btn[1]=btn2 (up), btn[2]=btn3 (down), btn[3]=btn4 (right).
  // btn1 has the highest priority when several pulse in the same cycle.
  function automatic dir_t btn_to_dir(input logic [3:0] btn);
    if (btn[0])      return DIR_LEFT;
    else if (btn[1]) return DIR_UP;
    else if (btn[2]) return DIR_DOWN;
    else             return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/move_cmd_sequencer_if.sv
// move_cmd_sequencer_if: command channel between the sequencer (master) and
// the 2048 board engine (slave).
//   move_valid/move_dir  command from the sequencer
//   move_ready           engine accepts the command
//   move_done            one-cycle pulse when the board move has finished
//   move_changed         qualifies move_done: the board changed
//   game_over            qualifies move_done: no legal moves remain
//
// Handshake: a command transfers on a cycle where move_valid and move_ready
// are both high. Once move_valid rises, move_valid and move_dir stay stable
// until that transfer. After the transfer the master issues nothing new
// until the engine pulses move_done.
interface move_cmd_sequencer_if;
  import game_pkg::*;

  logic move_valid;
  dir_t move_dir;
  logic move_ready;
  logic move_done;
  logic move_changed;
  logic game_over;

  modport master (
    output move_valid, move_dir,
    input  move_ready, move_done, move_changed, game_over
  );

  modport slave (
    input  move_valid, move_dir,
    output move_ready, move_done, move_changed, game_over
  );

endinterface

// File: rtl/dir_fifo.sv
// dir_fifo: circular FIFO of move directions.
//   push/push_dir  write request; accepted when not full, or when full with a pop in the same cycle
//   pop            remove the head entry (ignored when empty)
//   flush          empty the FIFO; overrides push and pop in the same cycle
//   head           current head entry
//   full/empty     occupancy flags
//   level          number of entries held
module dir_fifo
  import game_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  dir_t                        push_dir,
  input  logic                        pop,
  input  logic                        flush,
  output dir_t                        head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  dir_t          mem_q [FIFO_DEPTH];
  dir_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == LW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle;
  // the freed slot is the one the write pointer already points at.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dir;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after they are written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/move_cmd_sequencer.sv
// move_cmd_sequencer: game-mode FSM (menu / play / game over) sitting after the
// keyboard decoder. It queues direction presses and issues them one at a time
// to the board engine.
//   clk, reset          clock and synchronous active-high reset
//   btn1..btn4          direction pulses: left, up, down, right
//   rst, start, menu    control pulses; priority rst > menu > start
//   mv                  command channel to the board engine (master side)
//   board_clear         one-cycle pulse: clear board, spawn the initial tiles
//   menu/play/over_active  current game mode
//   move_count          effective moves this game (saturating)
//   q_level             direction queue occupancy
//   overflow            sticky: a direction press was dropped
//   dbg_state           current FSM state
module move_cmd_sequencer
  import game_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn1,
  input  logic                        btn2,
  input  logic                        btn3,
  input  logic                        btn4,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        menu,
  move_cmd_sequencer_if.master        mv,
  output logic                        board_clear,
  output logic                        menu_active,
  output logic                        play_active,
  output logic                        over_active,
  output logic [CNT_W-1:0]            move_count,
  output logic [$clog2(FIFO_DEPTH):0] q_level,
  output logic                        overflow,
  output state_t                      dbg_state
);

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       pend_rst_q, pend_rst_d;
  logic       pend_menu_q, pend_menu_d;

  logic [3:0] btn_vec;
  logic       play;
  logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  dir_t       fifo_head;

  assign btn_vec = {btn4, btn3, btn2, btn1};
  assign play    = (state_q == S_IDLE) || (state_q == S_ISSUE) || (state_q == S_WAIT);

  dir_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dir (btn_to_dir(btn_vec)),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (q_level)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    pend_rst_d  = pend_rst_q;
    pend_menu_d = pend_menu_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    case (state_q)
      S_MENU: begin
        if (rst || start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fifo_flush  = 1'b1;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        pend_rst_d  = 1'b0;
        pend_menu_d = 1'b0;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        if (rst) begin
          state_d = S_CLEAR;
        end else if (menu) begin
          state_d    = S_MENU;
          fifo_flush = 1'b1;
        end else if (!fifo_empty) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Control pulses are remembered, never used to abort the command.
        if (rst)  pend_rst_d  = 1'b1;
        if (menu) pend_menu_d = 1'b1;
        if (mv.move_ready) begin
          fifo_pop = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rst)  pend_rst_d  = 1'b1;
        if (menu) pend_menu_d = 1'b1;
        if (mv.move_done) begin
          if (mv.move_changed && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          pend_rst_d  = 1'b0;
          pend_menu_d = 1'b0;
          // A pulse arriving together with move_done counts as pending.
          if (pend_rst_q || rst) begin
            state_d = S_CLEAR;
          end else if (pend_menu_q || menu) begin
            state_d    = S_MENU;
            fifo_flush = 1'b1;
          end else if (mv.game_over) begin
            state_d    = S_OVER;
            fifo_flush = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_OVER: begin
        if (rst)        state_d = S_CLEAR;
        else if (menu)  state_d = S_MENU;
        else if (start) state_d = S_CLEAR;
      end
      default: state_d = S_MENU;
    endcase

    // Only one direction per cycle is offered; the FIFO decides acceptance.
    fifo_push = play & (|btn_vec);
    if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_MENU;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      pend_rst_q  <= 1'b0;
      pend_menu_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      pend_rst_q  <= pend_rst_d;
      pend_menu_q <= pend_menu_d;
    end
  end

  assign mv.move_valid = (state_q == S_ISSUE);
  assign mv.move_dir   = fifo_head;
  assign board_clear   = (state_q == S_CLEAR);
  assign menu_active   = (state_q == S_MENU);
  assign play_active   = play;
  assign over_active   = (state_q == S_OVER);
  assign move_count    = cnt_q;
  assign overflow      = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_move_cmd_sequencer.sv
module tb_move_cmd_sequencer;
  import game_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic btn1, btn2, btn3, btn4, rst, start, menu;
  logic board_clear, menu_active, play_active, over_active, overflow;
  logic [CW-1:0] move_count;
  logic [LW-1:0] q_level;
  state_t dbg_state;

  move_cmd_sequencer_if mif();

  move_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn1        (btn1),
    .btn2        (btn2),
    .btn3        (btn3),
    .btn4        (btn4),
    .rst         (rst),
    .start       (start),
    .menu        (menu),
    .mv          (mif),
    .board_clear (board_clear),
    .menu_active (menu_active),
    .play_active (play_active),
    .over_active (over_active),
    .move_count  (move_count),
    .q_level     (q_level),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: game mode, the queue of directions still to be issued,
  // the move counter, the overflow flag and remembered control pulses.
  localparam int MD_MENU = 0, MD_CLEAR = 1, MD_IDLE = 2, MD_ISSUE = 3, MD_WAIT = 4, MD_OVER = 5;
  int         md;
  logic [1:0] exp_q[$];
  int         m_cnt;
  bit         m_ovf, m_prst, m_pmenu;

  function automatic logic [1:0] pressed_dir();
    if (btn1)      return 2'd2;
    else if (btn2) return 2'd0;
    else if (btn3) return 2'd1;
    else           return 2'd3;
  endfunction

  task automatic model_reset();
    md = MD_MENU;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 0;
    m_prst = 0;
    m_pmenu = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int nmd;
    bit flush;
    bit popped;
    bit in_play;
    nmd = md;
    flush = 0;
    popped = 0;
    in_play = (md == MD_IDLE) || (md == MD_ISSUE) || (md == MD_WAIT);
    case (md)
      MD_MENU: if (rst || start) nmd = MD_CLEAR;
      MD_CLEAR: begin
        exp_q.delete();
        m_cnt = 0; m_ovf = 0; m_prst = 0; m_pmenu = 0;
        nmd = MD_IDLE;
      end
      MD_IDLE: begin
        if (rst) nmd = MD_CLEAR;
        else if (menu) begin nmd = MD_MENU; flush = 1; end
        else if (exp_q.size() != 0) nmd = MD_ISSUE;
      end
      MD_ISSUE: begin
        if (rst) m_prst = 1;
        if (menu) m_pmenu = 1;
        if (mif.move_ready) begin popped = 1; nmd = MD_WAIT; end
      end
      MD_WAIT: begin
        if (rst) m_prst = 1;
        if (menu) m_pmenu = 1;
        if (mif.move_done) begin
          if (mif.move_changed && m_cnt < (1 << CW) - 1) m_cnt++;
          if (m_prst) nmd = MD_CLEAR;
          else if (m_pmenu) begin nmd = MD_MENU; flush = 1; end
          else if (mif.game_over) begin nmd = MD_OVER; flush = 1; end
          else nmd = MD_IDLE;
          m_prst = 0;
          m_pmenu = 0;
        end
      end
      MD_OVER: begin
        if (rst) nmd = MD_CLEAR;
        else if (menu) nmd = MD_MENU;
        else if (start) nmd = MD_CLEAR;
      end
      default: ;
    endcase
    if (popped) void'(exp_q.pop_front());
    if (in_play && (btn1 || btn2 || btn3 || btn4) && !flush) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pressed_dir());
      else m_ovf = 1;
    end
    if (flush) exp_q.delete();
    md = nmd;
  endtask

  task automatic check_model();
    check_eq("move_valid", mif.move_valid, md == MD_ISSUE);
    if (md == MD_ISSUE) check_eq("move_dir", mif.move_dir, exp_q[0]);
    check_eq("board_clear", board_clear, md == MD_CLEAR);
    check_eq("menu_active", menu_active, md == MD_MENU);
    check_eq("play_active", play_active, (md == MD_IDLE) || (md == MD_ISSUE) || (md == MD_WAIT));
    check_eq("over_active", over_active, md == MD_OVER);
    check_eq("move_count", move_count, m_cnt);
    check_eq("q_level", q_level, exp_q.size());
    check_eq("overflow", overflow, m_ovf);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: apply inputs for one cycle, step the model,
  // then compare outputs at the next falling edge.
  task automatic drive(input logic [3:0] b, input logic r, input logic s, input logic m,
                       input logic rdy, input logic dn, input logic ch, input logic go);
    {btn4, btn3, btn2, btn1} = b;
    rst = r; start = s; menu = m;
    mif.move_ready = rdy; mif.move_done = dn; mif.move_changed = ch; mif.game_over = go;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    drive(4'b0000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] exp_dirs [4];
    logic [3:0] b;
    logic r, s, m, rdy, dn, ch, go;

    exp_dirs = '{2'd0, 2'd1, 2'd2, 2'd3};
    reset = 1'b1;
    {btn4, btn3, btn2, btn1} = 4'b0;
    rst = 0; start = 0; menu = 0;
    mif.move_ready = 0; mif.move_done = 0; mif.move_changed = 0; mif.game_over = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset.menu_active", menu_active, 1);
    check_eq("reset.move_valid", mif.move_valid, 0);
    check_model();

    // Start a game: one-cycle board clear, then play.
    drive(4'b0000, 0, 1, 0, 0, 0, 0, 0);
    check_eq("start.board_clear", board_clear, 1);
    check_eq("start.menu_active", menu_active, 0);
    idle();
    check_eq("start.board_clear_off", board_clear, 0);
    check_eq("start.play_active", play_active, 1);
    check_eq("start.move_count", move_count, 0);

    // Single up move: valid two cycles after the press.
    drive(4'b0010, 0, 0, 0, 1, 0, 0, 0);
    check_eq("lat.n1_valid", mif.move_valid, 0);
    drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
    check_eq("lat.n2_valid", mif.move_valid, 1);
    check_eq("lat.n2_dir", mif.move_dir, 0);
    drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 1, 1, 0);
    check_eq("lat.count", move_count, 1);
    check_eq("lat.play", play_active, 1);

    // Fill the queue past its depth with the engine stalled.
    drive(4'b0010, 0, 0, 0, 0, 0, 0, 0);
    drive(4'b0100, 0, 0, 0, 0, 0, 0, 0);
    drive(4'b0001, 0, 0, 0, 0, 0, 0, 0);
    drive(4'b1000, 0, 0, 0, 0, 0, 0, 0);
    drive(4'b0001, 0, 0, 0, 0, 0, 0, 0);
    check_eq("ovf.q_level", q_level, 4);
    check_eq("ovf.overflow", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf.valid", mif.move_valid, 1);
      check_eq("ovf.dir", mif.move_dir, exp_dirs[i]);
      drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
      drive(4'b0000, 0, 0, 0, 0, 1, 1, 0);
      idle();
    end
    check_eq("ovf.drained_valid", mif.move_valid, 0);
    check_eq("ovf.drained_level", q_level, 0);
    check_eq("ovf.count", move_count, 5);

    // Simultaneous left and right: only left is queued.
    drive(4'b1001, 0, 0, 0, 0, 0, 0, 0);
    check_eq("simul.q_level", q_level, 1);
    idle();
    check_eq("simul.dir", mif.move_dir, 2);
    drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 1, 1, 0);
    check_eq("simul.count", move_count, 6);

    // Menu during an in-flight move waits for move_done.
    drive(4'b0010, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
    drive(4'b0100, 0, 0, 1, 0, 0, 0, 0);
    check_eq("menu.still_play", play_active, 1);
    check_eq("menu.q_level", q_level, 1);
    drive(4'b0000, 0, 0, 0, 0, 1, 0, 0);
    check_eq("menu.menu_active", menu_active, 1);
    check_eq("menu.flushed", q_level, 0);
    check_eq("menu.count", move_count, 6);

    // Game over, ignored press, then game reset.
    drive(4'b0000, 0, 1, 0, 0, 0, 0, 0);
    idle();
    drive(4'b0010, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 1, 1, 0);
    drive(4'b1000, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(4'b0000, 0, 0, 0, 1, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0, 1, 0, 1);
    check_eq("over.active", over_active, 1);
    check_eq("over.count", move_count, 1);
    drive(4'b0100, 0, 0, 0, 0, 0, 0, 0);
    check_eq("over.ignored", q_level, 0);
    check_eq("over.still", over_active, 1);
    drive(4'b0000, 1, 0, 0, 0, 0, 0, 0);
    check_eq("over.clear", board_clear, 1);
    idle();
    check_eq("over.play", play_active, 1);
    check_eq("over.count_zero", move_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      b   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      r   = ($urandom_range(0, 59) == 0);
      m   = ($urandom_range(0, 49) == 0);
      s   = ($urandom_range(0, 9) == 0);
      rdy = 1'($urandom_range(0, 1));
      dn  = (md == MD_WAIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      ch  = ($urandom_range(0, 3) != 0);
      go  = ($urandom_range(0, 11) == 0);
      drive(b, r, s, m, rdy, dn, ch, go);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
